// File: rtl/score_packer.sv
// Packs NUM_CLASSES serial class scores into one wide frame for the argmax stage.
// Holds the frame, with a NaN summary flag, until downstream takes it.
module score_packer #(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_CLASSES = 10
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              in_valid,
  input  logic [DATA_WIDTH-1:0]             in_data,
  output logic                              in_ready,
  input  logic                              flush,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [DATA_WIDTH*NUM_CLASSES-1:0] n,
  output logic                              nan_flag,
  output logic [3:0]                        count,
  output logic                              state_dbg
);

  // Handshake: a word moves on a rising edge where in_valid && in_ready; a frame
  // moves on a rising edge where out_valid && out_ready. in_ready/out_valid are
  // decoded from the state register only, never from in_valid or out_ready.
  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  localparam logic [3:0] LAST = 4'(NUM_CLASSES - 1);

  state_t state, state_next;
  logic   accept;
  logic   last;
  logic   in_nan;

  assign in_ready  = (state == COLLECT);
  assign out_valid = (state == HOLD);
  assign state_dbg = state;

  // flush wins over a simultaneous in_valid, so the flushed-cycle word is dropped.
  assign accept = in_ready && in_valid && !flush;
  assign last   = accept && (count == LAST);
  assign in_nan = (in_data[30:23] == 8'hFF) && (in_data[22:0] != 23'd0);

  always_comb begin
    state_next = state;
    case (state)
      COLLECT: if (last)      state_next = HOLD;
      HOLD:    if (out_ready) state_next = COLLECT;
      default:                state_next = COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= COLLECT;
    else       state <= state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count    <= 4'd0;
      n        <= '0;
      nan_flag <= 1'b0;
    end else if (in_ready && flush) begin
      count    <= 4'd0;
      nan_flag <= 1'b0;
    end else if (accept) begin
      count    <= last ? 4'd0 : count + 4'd1;
      nan_flag <= (count == 4'd0) ? in_nan : (nan_flag | in_nan);
      // Class 0 lands in the MSBs; stale words from a flushed frame get overwritten.
      for (int i = 0; i < NUM_CLASSES; i++) begin
        if (count == 4'(i)) n[DATA_WIDTH*(NUM_CLASSES-1-i) +: DATA_WIDTH] <= in_data;
      end
    end
  end

endmodule

// File: tb/tb_score_packer.sv
// Self-checking bench for score_packer: frame scoreboard, NaN flag, flush,
// async reset, stall in HOLD and gapped input.
module tb_score_packer;
  localparam int DW = 32;
  localparam int NC = 10;
  localparam int W  = DW * NC;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  n;
  logic          nan_flag;
  logic [3:0]    count;
  logic          state_dbg;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] model_frame = '0;
  int           model_cnt   = 0;

  logic [DW-1:0] b2b_words [NC] = '{32'hbed801a1, 32'h3ef08166, 32'h3bd00600, 32'hbeba9d87,
                                   32'h3e13ae30, 32'hbe43c999, 32'h40a3a7c1, 32'h3e0e3b14,
                                   32'hbea7c6cb, 32'h3ee1a8a4};
  logic [W-1:0] golden = 320'hbed801a13ef081663bd00600beba9d873e13ae30be43c99940a3a7c13e0e3b14bea7c6cb3ee1a8a4;

  score_packer #(.DATA_WIDTH(DW), .NUM_CLASSES(NC)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .n(n),
    .nan_flag(nan_flag), .count(count), .state_dbg(state_dbg)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic send_word(input logic [DW-1:0] w);
    in_valid = 1'b1;
    in_data  = w;
    flush    = 1'b0;
    @(posedge clk); #1;
    model_frame = {model_frame[W-DW-1:0], w};
    model_cnt++;
    if (model_cnt == NC) begin
      exp_q.push_back(model_frame);
      model_cnt = 0;
    end
  endtask

  task automatic idle_cycle();
    in_valid = 1'b0;
    in_data  = $urandom;
    @(posedge clk); #1;
  endtask

  task automatic release_frame();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  function automatic logic [DW-1:0] rand_score();
    logic [DW-1:0] r;
    r     = $urandom;
    r[30] = 1'b0;
    return r;
  endfunction

  // Index of the largest IEEE-754 single in a packed frame, class 0 at the MSBs.
  function automatic int find_max(input logic [W-1:0] f);
    logic [31:0] w, key, best_key;
    int best;
    best = 0;
    best_key = '0;
    for (int i = 0; i < NC; i++) begin
      w   = f[W-1-DW*i -: DW];
      key = w[31] ? ~w : (w | 32'h8000_0000);
      if (i == 0 || key > best_key) begin
        best_key = key;
        best     = i;
      end
    end
    return best;
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    total++; if (count !== 4'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", count); end
    total++; if (n !== '0) begin bad++; $display("FAIL reset_n: got %h want 0", n); end
    total++; if (nan_flag !== 1'b0) begin bad++; $display("FAIL reset_nan: got %b want 0", nan_flag); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] exp_n;
    out_ready = 1'b0;
    for (int k = 0; k < NC; k++) begin
      send_word(b2b_words[k]);
      total++;
      if (count !== ((k == NC-1) ? 4'd0 : 4'(k+1))) begin
        bad++; $display("FAIL b2b_count k=%0d: got %0d want %0d", k, count, (k == NC-1) ? 0 : k+1);
      end
      total++;
      if (out_valid !== (k == NC-1)) begin
        bad++; $display("FAIL b2b_out_valid k=%0d: got %b want %b", k, out_valid, k == NC-1);
      end
    end
    exp_n = exp_q.pop_front();
    total++; if (n !== exp_n) begin bad++; $display("FAIL b2b_n_scoreboard: got %h want %h", n, exp_n); end
    total++; if (n !== golden) begin bad++; $display("FAIL b2b_n_golden: got %h want %h", n, golden); end
    total++; if (nan_flag !== 1'b0) begin bad++; $display("FAIL b2b_nan: got %b want 0", nan_flag); end
    total++; if (find_max(n) != 6) begin bad++; $display("FAIL b2b_findmax: got %0d want 6", find_max(n)); end
    total++; if (state_dbg !== 1'b1) begin bad++; $display("FAIL b2b_state_hold: got %b want 1", state_dbg); end
  endtask

  task automatic test_hold_stall();
    in_valid  = 1'b1;
    in_data   = 32'hFFFF_FFFF;
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      total++; if (n !== golden) begin bad++; $display("FAIL stall_n c=%0d: got %h want %h", c, n, golden); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready c=%0d: got %b want 0", c, in_ready); end
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stall_out_valid c=%0d: got %b want 1", c, out_valid); end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL release_out_valid: got %b want 0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL release_in_ready: got %b want 1", in_ready); end
    total++; if (count !== 4'd0) begin bad++; $display("FAIL release_count: got %0d want 0", count); end
  endtask

  task automatic test_nan();
    logic [W-1:0] exp_n;
    for (int k = 0; k < NC; k++) begin
      send_word((k == 3) ? 32'h7FC0_0000 : rand_score());
      if (k == 2) begin
        total++; if (nan_flag !== 1'b0) begin bad++; $display("FAIL nan_before: got %b want 0", nan_flag); end
      end
      if (k == 3) begin
        total++; if (nan_flag !== 1'b1) begin bad++; $display("FAIL nan_at_score3: got %b want 1", nan_flag); end
      end
    end
    exp_n = exp_q.pop_front();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL nan_out_valid: got %b want 1", out_valid); end
    total++; if (nan_flag !== 1'b1) begin bad++; $display("FAIL nan_hold: got %b want 1", nan_flag); end
    total++; if (n !== exp_n) begin bad++; $display("FAIL nan_n: got %h want %h", n, exp_n); end
    release_frame();
    for (int k = 0; k < NC; k++) begin
      send_word(rand_score());
      if (k == 0) begin
        total++; if (nan_flag !== 1'b0) begin bad++; $display("FAIL nan_cleared: got %b want 0", nan_flag); end
      end
    end
    exp_n = exp_q.pop_front();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL clean_out_valid: got %b want 1", out_valid); end
    total++; if (nan_flag !== 1'b0) begin bad++; $display("FAIL clean_nan: got %b want 0", nan_flag); end
    total++; if (n !== exp_n) begin bad++; $display("FAIL clean_n: got %h want %h", n, exp_n); end
    release_frame();
  endtask

  task automatic test_flush();
    logic [W-1:0] exp_n;
    for (int k = 0; k < 4; k++) send_word((k == 1) ? 32'h7F80_0001 : rand_score());
    total++; if (count !== 4'd4) begin bad++; $display("FAIL flush_pre_count: got %0d want 4", count); end
    total++; if (nan_flag !== 1'b1) begin bad++; $display("FAIL flush_pre_nan: got %b want 1", nan_flag); end
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'h7FFF_FFFF;
    @(posedge clk); #1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    model_cnt = 0;
    total++; if (count !== 4'd0) begin bad++; $display("FAIL flush_count: got %0d want 0", count); end
    total++; if (nan_flag !== 1'b0) begin bad++; $display("FAIL flush_nan: got %b want 0", nan_flag); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_in_ready: got %b want 1", in_ready); end
    for (int k = 0; k < NC; k++) send_word(rand_score());
    exp_n = exp_q.pop_front();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL flush_out_valid: got %b want 1", out_valid); end
    total++; if (n !== exp_n) begin bad++; $display("FAIL flush_n: got %h want %h", n, exp_n); end
    total++; if (nan_flag !== 1'b0) begin bad++; $display("FAIL flush_frame_nan: got %b want 0", nan_flag); end
    release_frame();
  endtask

  task automatic test_async_reset();
    logic [W-1:0] exp_n;
    for (int k = 0; k < 7; k++) send_word((k == 2) ? 32'h7FC0_0001 : rand_score());
    in_valid = 1'b0;
    #3 reset = 1'b1;
    #1;
    total++; if (count !== 4'd0) begin bad++; $display("FAIL areset_count: got %0d want 0", count); end
    total++; if (n !== '0) begin bad++; $display("FAIL areset_n: got %h want 0", n); end
    total++; if (nan_flag !== 1'b0) begin bad++; $display("FAIL areset_nan: got %b want 0", nan_flag); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL areset_in_ready: got %b want 1", in_ready); end
    #2 reset = 1'b0;
    model_cnt = 0;
    for (int k = 0; k < NC; k++) send_word(rand_score());
    exp_n = exp_q.pop_front();
    total++; if (n !== exp_n) begin bad++; $display("FAIL areset_frame_n: got %h want %h", n, exp_n); end
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL areset_frame_valid: got %b want 1", out_valid); end
    #3 reset = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL hold_reset_out_valid: got %b want 0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL hold_reset_in_ready: got %b want 1", in_ready); end
    total++; if (n !== '0) begin bad++; $display("FAIL hold_reset_n: got %h want 0", n); end
    #2 reset = 1'b0;
  endtask

  task automatic test_gaps();
    logic [W-1:0] exp_n;
    int hs;
    int cyc;
    hs  = 0;
    cyc = 0;
    while (hs < NC && cyc < 40) begin
      if (cyc % 2 == 0) begin
        send_word(rand_score());
        hs++;
      end else begin
        idle_cycle();
      end
      cyc++;
      total++;
      if (count !== ((hs == NC) ? 4'd0 : 4'(hs))) begin
        bad++; $display("FAIL gaps_count cyc=%0d: got %0d want %0d", cyc, count, (hs == NC) ? 0 : hs);
      end
      total++;
      if (out_valid !== (hs == NC)) begin
        bad++; $display("FAIL gaps_out_valid cyc=%0d: got %b want %b", cyc, out_valid, hs == NC);
      end
    end
    in_valid = 1'b0;
    exp_n = exp_q.pop_front();
    total++; if (n !== exp_n) begin bad++; $display("FAIL gaps_n: got %h want %h", n, exp_n); end
    release_frame();
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_back_to_back();
    test_hold_stall();
    test_nan();
    test_flush();
    test_async_reset();
    test_gaps();
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL scoreboard_drain: got %0d frames left want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
